// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scan controller with frame-aligned word commit.
// Optional build macro SEG_SCAN_LZB_EN adds leading-zero blanking of committed words.

module seg_seven_logic (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    case (hex)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

endmodule

module seg_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 100000,
  parameter int GUARD_CYCLES   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic [4*NUM_DIGITS-1:0] din_data,
  input  logic [NUM_DIGITS-1:0]   din_blank,
  input  logic [NUM_DIGITS-1:0]   din_dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              segment,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_END = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_OFF,
    S_GUARD,
    S_DRIVE
  } state_t;

  localparam state_t SLOT_START = (GUARD_CYCLES == 0) ? S_DRIVE : S_GUARD;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          frame_last;
  logic          frame_last_nxt;

  logic                    pend_full;
  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [NUM_DIGITS-1:0]   pend_blank;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    commit;
  logic                    accept;

  logic [4*NUM_DIGITS-1:0] act_data, act_data_nxt;
  logic [NUM_DIGITS-1:0]   act_blank, act_blank_nxt;
  logic [NUM_DIGITS-1:0]   act_dp, act_dp_nxt;
  logic [NUM_DIGITS-1:0]   act_lzb, act_lzb_nxt;
  logic [NUM_DIGITS-1:0]   lzb_new;

  logic [3:0]            sel_nib;
  logic                  sel_blank;
  logic                  sel_dp;
  logic                  sel_lzb;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] anode_nxt;
  logic [6:0]            segment_nxt;
  logic                  dp_nxt;

  assign frame_last = (state == S_DRIVE) && (idx == LAST_IDX) && (cnt == LAST_CNT);
  assign commit     = pend_full && ((state == S_OFF) || frame_last);
  assign accept     = din_valid && !pend_full;
  assign din_ready  = !pend_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_OFF;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // One counter spans the whole slot; guard and drive are ranges of it.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    if (!enable) begin
      state_nxt = S_OFF;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_OFF: begin
          state_nxt = SLOT_START;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
        S_GUARD: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == GUARD_END) state_nxt = S_DRIVE;
        end
        S_DRIVE: begin
          if (cnt == LAST_CNT) begin
            cnt_nxt   = '0;
            idx_nxt   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            state_nxt = SLOT_START;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = S_OFF;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign frame_last_nxt = (state_nxt == S_DRIVE) && (idx_nxt == LAST_IDX) &&
                          (cnt_nxt == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_full  <= 1'b0;
      pend_data  <= '0;
      pend_blank <= '0;
      pend_dp    <= '0;
    end else if (commit) begin
      pend_full <= 1'b0;
    end else if (accept) begin
      pend_full  <= 1'b1;
      pend_data  <= din_data;
      pend_blank <= din_blank;
      pend_dp    <= din_dp;
    end
  end

`ifdef SEG_SCAN_LZB_EN
  logic lz_run;

  // Zero nibbles above the most significant nonzero digit go dark; digit 0 always shows.
  always_comb begin
    lzb_new = '0;
    lz_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (pend_data[4*k +: 4] != 4'h0) lz_run = 1'b0;
      lzb_new[k] = lz_run;
    end
  end
`else
  assign lzb_new = '0;
`endif

  always_comb begin
    act_data_nxt  = act_data;
    act_blank_nxt = act_blank;
    act_dp_nxt    = act_dp;
    act_lzb_nxt   = act_lzb;
    if (commit) begin
      act_data_nxt  = pend_data;
      act_blank_nxt = pend_blank;
      act_dp_nxt    = pend_dp;
      act_lzb_nxt   = lzb_new;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_data  <= '0;
      act_blank <= '1;
      act_dp    <= '0;
      act_lzb   <= '0;
    end else begin
      act_data  <= act_data_nxt;
      act_blank <= act_blank_nxt;
      act_dp    <= act_dp_nxt;
      act_lzb   <= act_lzb_nxt;
    end
  end

  // Pins are driven from the upcoming state so each register matches the cycle it shows.
  assign sel_nib   = act_data_nxt[{idx_nxt, 2'b00} +: 4];
  assign sel_blank = act_blank_nxt[idx_nxt];
  assign sel_dp    = act_dp_nxt[idx_nxt];
  assign sel_lzb   = act_lzb_nxt[idx_nxt];

  seg_seven_logic u_dec (
    .hex (sel_nib),
    .seg (dec_seg)
  );

  always_comb begin
    anode_nxt   = '1;
    segment_nxt = 7'h7F;
    dp_nxt      = 1'b1;
    if ((state_nxt == S_DRIVE) && !sel_blank) begin
      if (!sel_lzb) begin
        anode_nxt[idx_nxt] = 1'b0;
        segment_nxt        = dec_seg;
        dp_nxt             = ~sel_dp;
      end else if (sel_dp) begin
        anode_nxt[idx_nxt] = 1'b0;
        dp_nxt             = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode      <= '1;
      segment    <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      anode      <= anode_nxt;
      segment    <= segment_nxt;
      dp         <= dp_nxt;
      frame_done <= frame_last_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl against a frame-position reference model.
// Honours SEG_SCAN_LZB_EN so the model tracks whichever build is compiled.

module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int R     = 8;
  localparam int G     = 2;
  localparam int FRAME = ND * R;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          din_valid;
  logic          din_ready;
  logic [15:0]   din_data;
  logic [3:0]    din_blank;
  logic [3:0]    din_dp;
  logic [3:0]    anode;
  logic [6:0]    segment;
  logic          dp;
  logic          frame_done;

  int checks   = 0;
  int failures = 0;

  // Reference state: position within the running frame (-1 while scanning is off).
  int          m_pos;
  logic [15:0] m_data;
  logic [3:0]  m_blank;
  logic [3:0]  m_dp;
  logic        m_full;
  logic [15:0] m_pdata;
  logic [3:0]  m_pblank;
  logic [3:0]  m_pdp;

  seg_scan_ctrl #(
    .NUM_DIGITS     (ND),
    .REFRESH_CYCLES (R),
    .GUARD_CYCLES   (G)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_data   (din_data),
    .din_blank  (din_blank),
    .din_dp     (din_dp),
    .anode      (anode),
    .segment    (segment),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  function automatic logic [6:0] hexSeg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [3:0] lzbOf(input logic [15:0] w);
    logic [3:0] m;
    int top;
    m = 4'b0000;
`ifdef SEG_SCAN_LZB_EN
    top = 0;
    for (int k = 0; k < ND; k++)
      if (((w >> (4 * k)) & 16'hF) != 16'h0) top = k;
    for (int k = 1; k < ND; k++)
      if (k > top) m[k] = 1'b1;
`else
    top = int'(w[0]);
    if (top > 1) m = 4'b0000;
`endif
    return m;
  endfunction

  task automatic modelOutputs(output logic [3:0] ea, output logic [6:0] es, output logic ed);
    int k;
    logic [3:0] lz;
    logic [3:0] nib;
    ea = 4'hF;
    es = 7'h7F;
    ed = 1'b1;
    if (m_pos >= 0 && (m_pos % R) >= G) begin
      k   = m_pos / R;
      lz  = lzbOf(m_data);
      nib = 4'((m_data >> (4 * k)) & 16'hF);
      if (!m_blank[k]) begin
        if (!lz[k]) begin
          ea[k] = 1'b0;
          es    = hexSeg(nib);
          ed    = ~m_dp[k];
        end else if (m_dp[k]) begin
          ea[k] = 1'b0;
          ed    = 1'b0;
        end
      end
    end
  endtask

  // Reference model update on each edge (and immediately on reset).
  initial begin
    m_pos = -1; m_data = '0; m_blank = '1; m_dp = '0;
    m_full = 1'b0; m_pdata = '0; m_pblank = '0; m_pdp = '0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_pos = -1; m_data = '0; m_blank = '1; m_dp = '0;
        m_full = 1'b0;
      end else begin
        if (m_full && (m_pos < 0 || m_pos == FRAME - 1)) begin
          m_data = m_pdata; m_blank = m_pblank; m_dp = m_pdp;
          m_full = 1'b0;
        end else if (din_valid && !m_full) begin
          m_pdata = din_data; m_pblank = din_blank; m_pdp = din_dp;
          m_full = 1'b1;
        end
        if (!enable)        m_pos = -1;
        else if (m_pos < 0) m_pos = 0;
        else                m_pos = (m_pos + 1) % FRAME;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    forever begin
      @(negedge clk);
      modelOutputs(ea, es, ed);
      checkOutput("anode", 32'(anode), 32'(ea));
      checkOutput("segment", 32'(segment), 32'(es));
      checkOutput("dp", 32'(dp), 32'(ed));
      checkOutput("frame_done", 32'(frame_done), 32'(m_pos == FRAME - 1));
      checkOutput("din_ready", 32'(din_ready), 32'(!m_full));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic waitPos(input int p);
    int n;
    n = 0;
    while (m_pos != p && n < 200) begin
      step();
      n++;
    end
    if (m_pos != p) begin
      checks++;
      failures++;
      $display("[TB] FAIL waitPos actual=%0d required=%0d", m_pos, p);
    end
  endtask

  task automatic offerWord(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    din_data  = d;
    din_blank = b;
    din_dp    = p;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int cycles);
    logic [15:0] w;
    for (int i = 0; i < cycles; i++) begin
      step();
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      din_valid = ($urandom_range(0, 3) == 0);
      w = 16'($urandom);
      if ($urandom_range(0, 1) == 1) w = w >> (4 * $urandom_range(0, 4));
      din_data  = w;
      din_blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      din_dp    = 4'($urandom);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; din_valid = 1'b0;
    din_data = '0; din_blank = '0; din_dp = '0;
    step();
    step();
    reset = 1'b0;

    // Load while off, then scan.
    offerWord(16'h1234, 4'b0000, 4'b0010);
    step();
    enable = 1'b1;
    waitPos(2);  #4;
    checkOutput("slot0_anode", 32'(anode), 32'h0000000E);
    checkOutput("slot0_seg", 32'(segment), 32'h19);
    checkOutput("slot0_dp", 32'(dp), 32'h1);
    waitPos(10); #4;
    checkOutput("slot1_anode", 32'(anode), 32'h0000000D);
    checkOutput("slot1_seg", 32'(segment), 32'h30);
    checkOutput("slot1_dp", 32'(dp), 32'h0);
    waitPos(31); #4;
    checkOutput("frame_done_hi", 32'(frame_done), 32'h1);
    waitPos(0);  #4;
    checkOutput("frame_done_lo", 32'(frame_done), 32'h0);

    // Backpressure: A mid-frame, B held until ready rises.
    waitPos(5);
    din_data = 16'h0009; din_blank = 4'b0000; din_dp = 4'b0000; din_valid = 1'b1;
    step();
    din_data = 16'h000A;
    #4;
    checkOutput("bp_ready_low", 32'(din_ready), 32'h0);
    waitPos(31);
    waitPos(0);  #4;
    checkOutput("bp_ready_high", 32'(din_ready), 32'h1);
    waitPos(2);  #4;
    checkOutput("bp_word_a", 32'(segment), 32'h10);
    din_valid = 1'b0;
    waitPos(31);
    waitPos(2);  #4;
    checkOutput("bp_word_b", 32'(segment), 32'h08);

    // Enable drop in digit 2 and restart.
    waitPos(18);
    enable = 1'b0;
    step(); #4;
    checkOutput("drop_anode", 32'(anode), 32'h0000000F);
    checkOutput("drop_seg", 32'(segment), 32'h7F);
    enable = 1'b1;
    step(); #4;
    checkOutput("restart_guard0", 32'(anode), 32'h0000000F);
    step(); #4;
    checkOutput("restart_guard1", 32'(anode), 32'h0000000F);
    step(); #4;
    checkOutput("restart_drive", 32'(anode), 32'h0000000E);

    // Blank mask on digit 2.
    offerWord(16'h5678, 4'b0100, 4'b0000);
    waitPos(31);
    waitPos(10); #4;
    checkOutput("blank_slot1", 32'(segment), 32'h78);
    waitPos(18); #4;
    checkOutput("blank_slot2a", 32'(anode), 32'h0000000F);
    waitPos(23); #4;
    checkOutput("blank_slot2b", 32'(anode), 32'h0000000F);
    waitPos(26); #4;
    checkOutput("blank_slot3", 32'(anode), 32'h00000007);

    // Leading zeros.
    offerWord(16'h0050, 4'b0000, 4'b0000);
    waitPos(31);
    waitPos(2);  #4;
    checkOutput("lz_slot0", 32'(segment), 32'h40);
    waitPos(10); #4;
    checkOutput("lz_slot1", 32'(segment), 32'h12);
    waitPos(26); #4;
`ifdef SEG_SCAN_LZB_EN
    checkOutput("lz_slot3_anode", 32'(anode), 32'h0000000F);
    checkOutput("lz_slot3_seg", 32'(segment), 32'h7F);
`else
    checkOutput("lz_slot3_anode", 32'(anode), 32'h00000007);
    checkOutput("lz_slot3_seg", 32'(segment), 32'h40);
`endif

    // Reset mid-drive with a word pending.
    waitPos(3);
    offerWord(16'hFFFF, 4'b0000, 4'b0000);
    waitPos(12);
    reset = 1'b1;
    #4;
    checkOutput("rst_anode", 32'(anode), 32'h0000000F);
    checkOutput("rst_seg", 32'(segment), 32'h7F);
    checkOutput("rst_dp", 32'(dp), 32'h1);
    checkOutput("rst_ready", 32'(din_ready), 32'h1);
    checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
    step();
    reset = 1'b0;
    waitPos(2);  #4;
    checkOutput("rst_discard", 32'(anode), 32'h0000000F);

    applyStimulus(3000);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
